// File: rtl/dm_store_buf_pkg.sv
// Store-op encodings, buffered entry layout and the store alignment helpers.
// The load extender and the control decoder import the same package.
package dm_store_buf_pkg;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_B    = 2'b01;
    localparam logic [1:0] ST_H    = 2'b10;
    localparam logic [1:0] ST_W    = 2'b11;

    // One buffered store: word address, byte lanes and lane-replicated data.
    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } st_entry_t;

    // Returns {be, wdata}. Data is replicated across lanes so the memory
    // only needs the byte enables to pick the right bytes.
    function automatic logic [35:0] st_align(input logic [1:0]  op,
                                             input logic [1:0]  addr,
                                             input logic [31:0] data);
        logic [3:0]  be;
        logic [31:0] wdata;
        be    = 4'b0000;
        wdata = 32'h0;
        case (op)
            ST_B: begin
                be    = 4'b0001 << addr;
                wdata = {4{data[7:0]}};
            end
            ST_H: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
            end
            ST_W: begin
                be    = 4'b1111;
                wdata = data;
            end
            default: begin
                be    = 4'b0000;
                wdata = 32'h0;
            end
        endcase
        return {be, wdata};
    endfunction

    // Halfwords need an even address, words a word-aligned one.
    function automatic logic st_misaligned(input logic [1:0] op,
                                           input logic [1:0] addr);
        return ((op == ST_H) && addr[0]) || ((op == ST_W) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/dm_store_buf_fifo.sv
// Small store FIFO with async reset. Entries are plain registers so the
// hazard comparators can see every slot's address and occupancy at once.
module store_fifo
    import dm_store_buf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  st_entry_t              push_entry,
    input  logic                   pop,
    output st_entry_t              head,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH-1:0]       entry_valid,
    output logic [DEPTH-1:0][29:0] entry_waddr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    st_entry_t     mem_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW:0]   count_reg;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] offset;

            // Each slot captures the incoming entry when the write pointer is on it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= push_entry;
                end
            end

            // A slot is occupied if it lies within count positions of the head.
            assign offset          = PW'(gi) - rd_ptr_reg;
            assign entry_valid[gi] = ({1'b0, offset} < count_reg);
            assign entry_waddr[gi] = mem_reg[gi].waddr;
        end
    endgenerate

    assign head  = mem_reg[rd_ptr_reg];
    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/dm_store_buf.sv
// Store buffer: aligns sb/sh/sw requests, flags misaligned stores, queues
// them for the memory port and reports loads hitting a pending store.
module dm_store_buf
    import dm_store_buf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        st_exc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    output logic        mem_wvalid,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_wready,
    output logic        busy
);

    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [35:0]            aligned;
    st_entry_t              push_entry;
    st_entry_t              head;
    logic [DEPTH-1:0]       entry_valid;
    logic [DEPTH-1:0][29:0] entry_waddr;
    logic [DEPTH-1:0]       hit;
    logic                   unused_ld_bits;

    // Hazard compares are word-granular, so the load byte offset is irrelevant.
    assign unused_ld_bits = &{1'b0, ld_addr[1:0]};

    assign st_exc   = st_valid && st_misaligned(st_op, st_addr[1:0]);
    assign st_ready = !full;
    assign push     = st_valid && (st_op != ST_NONE) && !st_exc && st_ready;
    assign pop      = mem_wvalid && mem_wready;

    assign aligned    = st_align(st_op, st_addr[1:0], st_data);
    assign push_entry = '{waddr: st_addr[31:2], be: aligned[35:32], wdata: aligned[31:0]};

    store_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .entry_valid (entry_valid),
        .entry_waddr (entry_waddr)
    );

    assign mem_wvalid = !empty;
    assign busy       = !empty;
    assign mem_addr   = {head.waddr, 2'b00};
    assign mem_be     = head.be;
    assign mem_wdata  = head.wdata;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit[gi] = entry_valid[gi] && (entry_waddr[gi] == ld_addr[31:2]);
        end
    endgenerate

    assign ld_hazard = ld_valid && (|hit);

endmodule

// File: tb/tb_dm_store_buf.sv
// Directed scenarios plus a randomized run checked against a queue model.
module tb_dm_store_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_exc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_wvalid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_wready;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];

    dm_store_buf #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_op      (st_op),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .st_exc     (st_exc),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_hazard  (ld_hazard),
        .mem_wvalid (mem_wvalid),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        st_valid   = 1'b0;
        st_op      = 2'b00;
        st_addr    = 32'h0;
        st_data    = 32'h0;
        ld_valid   = 1'b0;
        ld_addr    = 32'h0;
        mem_wready = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #2;
        tests_run++;
        if (mem_wvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_wvalid got %b want 0", mem_wvalid); end
        tests_run++;
        if (mem_be !== 4'b0) begin tests_failed++; $display("FAIL reset_be got %b want 0000", mem_be); end
        tests_run++;
        if (st_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", st_ready); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++; $display("FAIL reset_head got addr=%h data=%h want 0/0", mem_addr, mem_wdata);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_sb();
        tick();
        drive_store(2'b01, 32'h0000_1003, 32'h0000_00A5);
        mem_wready = 1'b1;
        tick();
        st_valid = 1'b0;
        tests_run++;
        if (mem_wvalid !== 1'b1 || mem_addr !== 32'h1000 || mem_be !== 4'b1000 || mem_wdata !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("FAIL sb_head got v=%b a=%h be=%b d=%h want 1 00001000 1000 a5a5a5a5",
                     mem_wvalid, mem_addr, mem_be, mem_wdata);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL sb_drain busy got %b want 0", busy); end
        mem_wready = 1'b0;
        $display("[TB] sb 0x1003 -> addr 0x1000 be 1000");
    endtask

    task automatic test_misaligned();
        drive_store(2'b10, 32'h2001, 32'hFFFF_0001);
        #1;
        tests_run++;
        if (st_exc !== 1'b1) begin tests_failed++; $display("FAIL mis_sh exc got %b want 1", st_exc); end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL mis_sh busy got %b want 0", busy); end
        drive_store(2'b11, 32'h2002, 32'h1111_2222);
        #1;
        tests_run++;
        if (st_exc !== 1'b1) begin tests_failed++; $display("FAIL mis_sw exc got %b want 1", st_exc); end
        tick();
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL mis_sw busy got %b want 0", busy); end
        drive_store(2'b10, 32'h2002, 32'h1234BEEF);
        #1;
        tests_run++;
        if (st_exc !== 1'b0) begin tests_failed++; $display("FAIL sh_ok exc got %b want 0", st_exc); end
        tick();
        st_valid = 1'b0;
        tests_run++;
        if (mem_wvalid !== 1'b1 || mem_addr !== 32'h2000 || mem_be !== 4'b1100 || mem_wdata !== 32'hBEEFBEEF) begin
            tests_failed++;
            $display("FAIL sh_ok_head got v=%b a=%h be=%b d=%h want 1 00002000 1100 beefbeef",
                     mem_wvalid, mem_addr, mem_be, mem_wdata);
        end
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL sh_ok_drain busy got %b want 0", busy); end
        $display("[TB] misaligned sh/sw rejected, sh 0x2002 be 1100");
    endtask

    task automatic test_back_to_back();
        mem_wready = 1'b0;
        drive_store(2'b11, 32'h10, 32'hAAAA_0010);
        tick();
        drive_store(2'b11, 32'h14, 32'hBBBB_0014);
        tick();
        drive_store(2'b11, 32'h18, 32'hCCCC_0018);
        tests_run++;
        if (st_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full ready got %b want 0", st_ready); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (mem_addr !== 32'h10 || mem_wdata !== 32'hAAAA0010 || st_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d] got a=%h d=%h rdy=%b want 00000010 aaaa0010 0", i, mem_addr, mem_wdata, st_ready);
            end
        end
        // Full with a pop in the same cycle: the third store still waits.
        mem_wready = 1'b1;
        tick();
        tests_run++;
        if (mem_addr !== 32'h14 || mem_wdata !== 32'hBBBB0014 || st_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_second got a=%h d=%h rdy=%b want 00000014 bbbb0014 1", mem_addr, mem_wdata, st_ready);
        end
        tick();
        st_valid = 1'b0;
        tests_run++;
        if (mem_wvalid !== 1'b1 || mem_addr !== 32'h18 || mem_wdata !== 32'hCCCC0018) begin
            tests_failed++;
            $display("FAIL bp_third got v=%b a=%h d=%h want 1 00000018 cccc0018", mem_wvalid, mem_addr, mem_wdata);
        end
        tick();
        mem_wready = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_drain busy got %b want 0", busy); end
        $display("[TB] backpressure drained 0x10 0x14 0x18 in order");
    endtask

    task automatic test_hazard();
        mem_wready = 1'b0;
        drive_store(2'b01, 32'h3001, 32'h77);
        ld_valid = 1'b1;
        ld_addr  = 32'h3002;
        #1;
        tests_run++;
        if (ld_hazard !== 1'b0) begin tests_failed++; $display("FAIL hz_same_cycle got %b want 0", ld_hazard); end
        tick();
        st_valid = 1'b0;
        #1;
        tests_run++;
        if (ld_hazard !== 1'b1) begin tests_failed++; $display("FAIL hz_hit got %b want 1", ld_hazard); end
        ld_addr = 32'h3004;
        #1;
        tests_run++;
        if (ld_hazard !== 1'b0) begin tests_failed++; $display("FAIL hz_other_word got %b want 0", ld_hazard); end
        ld_addr  = 32'h3002;
        ld_valid = 1'b0;
        #1;
        tests_run++;
        if (ld_hazard !== 1'b0) begin tests_failed++; $display("FAIL hz_no_load got %b want 0", ld_hazard); end
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        ld_valid   = 1'b1;
        #1;
        tests_run++;
        if (ld_hazard !== 1'b0) begin tests_failed++; $display("FAIL hz_after_drain got %b want 0", ld_hazard); end
        ld_valid = 1'b0;
        $display("[TB] load hazard on 0x3002 vs pending sb 0x3001");
    endtask

    task automatic test_async_reset();
        mem_wready = 1'b0;
        drive_store(2'b11, 32'h20, 32'h1);
        tick();
        drive_store(2'b11, 32'h24, 32'h2);
        tick();
        st_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL ar_pending busy got %b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (mem_wvalid !== 1'b0 || busy !== 1'b0 || st_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ar_immediate got v=%b busy=%b rdy=%b want 0 0 1", mem_wvalid, busy, st_ready);
        end
        tick();
        reset = 1'b0;
        drive_store(2'b11, 32'h40, 32'hDEAD_BEEF);
        mem_wready = 1'b1;
        tick();
        st_valid = 1'b0;
        tests_run++;
        if (mem_wvalid !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL ar_new got v=%b a=%h d=%h want 1 00000040 deadbeef", mem_wvalid, mem_addr, mem_wdata);
        end
        tick();
        mem_wready = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL ar_drain busy got %b want 0", busy); end
        $display("[TB] async reset discarded pending stores");
    endtask

    // Randomized traffic against a queue model of the buffer.
    task automatic test_random();
        logic [1:0]  a_lo;
        logic [3:0]  exp_be;
        logic [31:0] exp_data;
        logic        exp_exc;
        logic        exp_hz;
        logic        exp_ready;
        logic        do_push;
        logic        do_pop;
        ent_t        e;
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            st_valid   = ($urandom_range(0, 3) != 0);
            st_op      = 2'($urandom_range(0, 3));
            st_addr    = 32'h5000 + 32'($urandom_range(0, 31));
            st_data    = $urandom;
            ld_valid   = $urandom_range(0, 1) == 1;
            ld_addr    = 32'h5000 + 32'($urandom_range(0, 31));
            mem_wready = ($urandom_range(0, 2) == 0);
            #3;
            a_lo      = st_addr[1:0];
            exp_exc   = st_valid && ((st_op == 2'b10 && (a_lo % 2 == 1)) || (st_op == 2'b11 && a_lo != 0));
            exp_ready = (q.size() < DEPTH);
            exp_hz    = 1'b0;
            foreach (q[k]) if ((q[k].addr / 4) == (ld_addr / 4)) exp_hz = ld_valid;
            tests_run++;
            if (st_exc !== exp_exc || st_ready !== exp_ready || ld_hazard !== exp_hz ||
                mem_wvalid !== (q.size() != 0) || busy !== (q.size() != 0)) begin
                tests_failed++;
                $display("FAIL rnd_ctrl[%0d] got exc=%b rdy=%b hz=%b v=%b busy=%b want %b %b %b %b %b",
                         cyc, st_exc, st_ready, ld_hazard, mem_wvalid, busy,
                         exp_exc, exp_ready, exp_hz, q.size() != 0, q.size() != 0);
            end
            if (q.size() != 0) begin
                tests_run++;
                if (mem_addr !== q[0].addr || mem_be !== q[0].be || mem_wdata !== q[0].data) begin
                    tests_failed++;
                    $display("FAIL rnd_head[%0d] got a=%h be=%b d=%h want %h %b %h",
                             cyc, mem_addr, mem_be, mem_wdata, q[0].addr, q[0].be, q[0].data);
                end
            end
            do_pop  = (q.size() != 0) && mem_wready;
            do_push = st_valid && (st_op != 2'b00) && !exp_exc && exp_ready;
            if (do_pop) begin
                $display("[TB] rnd %0d drain addr=%h be=%b data=%h", cyc, q[0].addr, q[0].be, q[0].data);
                void'(q.pop_front());
            end
            if (do_push) begin
                case (st_op)
                    2'b01: begin
                        exp_be   = 4'(1 << a_lo);
                        exp_data = st_data[7:0] * 32'h0101_0101;
                    end
                    2'b10: begin
                        exp_be   = (a_lo >= 2) ? 4'b1100 : 4'b0011;
                        exp_data = st_data[15:0] * 32'h0001_0001;
                    end
                    default: begin
                        exp_be   = 4'b1111;
                        exp_data = st_data;
                    end
                endcase
                e.addr = st_addr - 32'(a_lo);
                e.be   = exp_be;
                e.data = exp_data;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_sb();
        test_misaligned();
        test_back_to_back();
        test_hazard();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dm_store_buf.md
# dm_store_buf

Store-side counterpart of the data-memory load extender. Accepts committed sb/sh/sw requests from the M stage and checks alignment. Converts each request into a word address, a byte-enable mask and lane-replicated write data, then holds it in a small FIFO. Entries drain to the data memory/bridge over a valid/ready handshake, and the block flags loads that hit a still-pending store.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `st_valid`  in  1  store request present this cycle.
- `st_op`  in  2  00 none, 01 sb, 10 sh, 11 sw.
- `st_addr`  in  32  byte address.
- `st_data`  in  32  register data; the low byte or halfword is used for sb/sh.
- `st_ready`  out  1  high when the FIFO is not full.
- `st_exc`  out  1  misaligned-store (AdES) flag, combinational.
- `ld_valid`  in  1  load in M stage.
- `ld_addr`  in  32  load byte address.
- `ld_hazard`  out  1  load word matches a pending store.
- `mem_wvalid`  out  1  head entry valid.
- `mem_addr`  out  32  head word address, bits [1:0] = 00.
- `mem_be`  out  4  head byte enables.
- `mem_wdata`  out  32  head aligned data.
- `mem_wready`  in  1  memory accepts the head entry.
- `busy`  out  1  FIFO non-empty.

## Operation
- **Misalignment:**
  - `st_exc` = `st_valid` & ((sh & `addr[0]`) | (sw & `addr[1:0]`≠0)).
  - It does not depend on `st_ready`.
  - A misaligned store is never enqueued.
- **Push condition:** `st_valid` & `st_op`≠00 & !`st_exc` & `st_ready`.
- **Alignment rules:**
  - sb: be = 4'b0001 << `addr[1:0]`; data = {4{d[7:0]}}.
  - sh: be = `addr[1]` ? 4'b1100 : 4'b0011; data = {2{d[15:0]}}.
  - sw: be = 4'b1111; data = d.
  - All ops: stored address = {`addr[31:2]`, 2'b00}.
- **Pop condition:** `mem_wvalid` & `mem_wready`.
- **Outputs:** `mem_*` are driven directly from the head entry registers. `mem_wvalid` = count≠0 = `busy`.
- **Ordering:** strict FIFO; entries drain in acceptance order.
- **Load hazard:** `ld_hazard` = `ld_valid` & OR over valid entries of (entry `addr[31:2]` == `ld_addr[31:2]`). It checks buffered entries only, not a store presented in the same cycle. The pipeline stalls the load while the flag is high.
- **Idle requests:** `st_op`=00 with `st_valid`=1 is ignored; no push and no exception.

## Timing
- **Reset** (async, immediate):
  - count, read pointer and write pointer all 0.
  - All entry registers 0, so `mem_wvalid`, `mem_addr`, `mem_be`, `mem_wdata` and `busy` are 0.
  - `st_ready`=1.
- **Latency:** a store pushed in cycle N appears on `mem_*` in cycle N+1 at the earliest, if the FIFO was empty.
- **Full:**
  - `st_ready` depends only on count. When count==DEPTH it is 0, even if a pop occurs in the same cycle; there is no full pass-through.
  - A store offered while full is not taken, and the M stage stalls.
- **Empty:** `mem_wvalid`=0. The mem outputs show the stale head slot and must be ignored.
- **Simultaneous push and pop** (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- **Stability:** while `mem_wvalid` & !`mem_wready`, `mem_addr`/`mem_be`/`mem_wdata` hold stable.
- **Pointers:** wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- **Reset mid-transfer:** all pending stores are discarded and `mem_wvalid` drops asynchronously.
- **Combinational outputs:** `ld_hazard` and `st_exc` are combinational and settle within the same cycle.

## Structure
- **Shared package** (also used by the load extender and the control decoder):
  - store-op constants `ST_NONE`/`ST_B`/`ST_H`/`ST_W`.
  - function `st_align(op, addr[1:0], data)` returning {be, wdata}.
  - function `st_misaligned(op, addr[1:0])`.
- **Sub-module `store_fifo`:** generic DEPTH×(30+4+32) synchronous FIFO with async reset. It exposes per-entry address and valid vectors for the hazard compare.
- **Top level:** alignment, exception and hazard logic.

## Test plan
- **Reset:** assert reset, release -> `mem_wvalid`=0, `mem_be`=0, `st_ready`=1, `busy`=0.
- **sb at address 0x1003:** data 0x000000A5, `mem_wready`=1 -> next cycle `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5; popped the same cycle, `busy`=0 after.
- **Misaligned stores:** sh at 0x2001 and sw at 0x2002 -> `st_exc`=1 in the same cycle, no push, `busy` stays 0. sh at 0x2002 with data 0x1234BEEF -> be=1100, wdata=0xBEEFBEEF.
- **Backpressure, DEPTH=2:** `mem_wready`=0, push sw 0x10 and sw 0x14 -> `st_ready`=0. A third store is held, and `mem_*` stays at 0x10 for 5 cycles. Raise `mem_wready` -> drains in order 0x10 then 0x14, then the third store.
- **Load hazard:** pending sb at 0x3001 and load at 0x3002 -> `ld_hazard`=1. Load at 0x3004 -> 0. After the drain, load at 0x3002 -> 0.
- **Async reset mid-transfer:** two entries pending with `mem_wready`=0; assert reset between clock edges -> `mem_wvalid`=0 and `busy`=0 immediately. After release, a new sw is issued alone.
